// File: rtl/mem_responder.sv
// Single-port word memory that sweeps itself to a known pattern after reset,
// then serves one-cycle-latency reads and same-edge writes (read-before-write).
module mem_responder #(
  parameter int DATA_WIDTH   = 16,
  parameter int ADDR_WIDTH   = 5,
  parameter int INIT_PATTERN = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] mem_address,
  input  logic                  mem_read_enable,
  input  logic                  mem_write_enable,
  input  logic [DATA_WIDTH-1:0] mem_data_in,
  output logic [DATA_WIDTH-1:0] mem_data_out,
  output logic                  data_valid,
  output logic                  init_done,
  output logic                  collision
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic {
    INIT,
    SERVE
  } state_t;

  state_t                  state, state_next;
  logic [ADDR_WIDTH-1:0]   ptr, ptr_next;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic                    write_en;
  logic [ADDR_WIDTH-1:0]   write_addr;
  logic [DATA_WIDTH-1:0]   write_data;
  logic                    read_accept;

  function automatic logic [DATA_WIDTH-1:0] init_word(input logic [ADDR_WIDTH-1:0] idx);
    if (INIT_PATTERN == 1) return DATA_WIDTH'(idx);
    return '0;
  endfunction

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= INIT;
      ptr   <= '0;
    end else begin
      state <= state_next;
      ptr   <= ptr_next;
    end
  end

  // INIT owns the write port; port requests only matter in SERVE.
  always_comb begin
    state_next  = state;
    ptr_next    = ptr;
    write_en    = 1'b0;
    write_addr  = mem_address;
    write_data  = mem_data_in;
    read_accept = 1'b0;
    case (state)
      INIT: begin
        write_en   = 1'b1;
        write_addr = ptr;
        write_data = init_word(ptr);
        ptr_next   = ptr + 1'b1;
        if (ptr == ADDR_WIDTH'(DEPTH - 1)) state_next = SERVE;
      end
      SERVE: begin
        write_en    = mem_write_enable;
        read_accept = mem_read_enable;
      end
      default: state_next = INIT;
    endcase
  end

  assign init_done = (state == SERVE);

  // Storage array: no reset, contents are defined by the INIT sweep.
  always_ff @(posedge clock) begin
    if (write_en) mem[write_addr] <= write_data;
  end

  // Read stage: old contents are sampled on the same edge a write lands.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mem_data_out <= '0;
      data_valid   <= 1'b0;
      collision    <= 1'b0;
    end else begin
      data_valid <= read_accept;
      collision  <= read_accept && mem_write_enable;
      if (read_accept) mem_data_out <= mem[mem_address];
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: two instances (zero and index init patterns) share
// stimulus and are compared every cycle against an array-based reference.
module tb_mem_responder;

  logic        clock = 1'b0;
  logic        reset;
  logic [4:0]  addr;
  logic        rd_en, wr_en;
  logic [15:0] din;
  logic [15:0] dout0, dout1;
  logic        dv0, dv1, id0, id1, co0, co1;

  int n_checks = 0;
  int n_errors = 0;

  // reference state
  logic [15:0] m0 [32];
  logic [15:0] m1 [32];
  int          init_count;
  logic [15:0] eo0, eo1;
  logic        ev, ec;

  mem_responder #(.DATA_WIDTH(16), .ADDR_WIDTH(5), .INIT_PATTERN(0)) dut0 (
    .clock(clock), .reset(reset), .mem_address(addr),
    .mem_read_enable(rd_en), .mem_write_enable(wr_en), .mem_data_in(din),
    .mem_data_out(dout0), .data_valid(dv0), .init_done(id0), .collision(co0)
  );

  mem_responder #(.DATA_WIDTH(16), .ADDR_WIDTH(5), .INIT_PATTERN(1)) dut1 (
    .clock(clock), .reset(reset), .mem_address(addr),
    .mem_read_enable(rd_en), .mem_write_enable(wr_en), .mem_data_in(din),
    .mem_data_out(dout1), .data_valid(dv1), .init_done(id1), .collision(co1)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m0[i] = 16'h0000;
      m1[i] = 16'(i);
    end
    init_count = 0;
    eo0 = '0; eo1 = '0; ev = 1'b0; ec = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_dout0"}, 32'(dout0), 0);
    check({tag, "_dout1"}, 32'(dout1), 0);
    check({tag, "_dv"}, {30'd0, dv0, dv1}, 0);
    check({tag, "_init_done"}, {30'd0, id0, id1}, 0);
    check({tag, "_coll"}, {30'd0, co0, co1}, 0);
  endtask

  task automatic compare_all();
    check("init_done0", 32'(id0), 32'(init_count >= 32));
    check("init_done1", 32'(id1), 32'(init_count >= 32));
    check("valid0", 32'(dv0), 32'(ev));
    check("valid1", 32'(dv1), 32'(ev));
    check("coll0", 32'(co0), 32'(ec));
    check("coll1", 32'(co1), 32'(ec));
    check("dout0", 32'(dout0), 32'(eo0));
    check("dout1", 32'(dout1), 32'(eo1));
  endtask

  // Drive one request, let one rising edge take it, check at the falling edge.
  task automatic step(input logic rd, input logic wr, input logic [4:0] a, input logic [15:0] d);
    rd_en = rd; wr_en = wr; addr = a; din = d;
    @(posedge clock);
    if (init_count < 32) begin
      init_count++;
      ev = 1'b0;
      ec = 1'b0;
    end else begin
      ev = rd;
      ec = rd && wr;
      if (rd) begin
        eo0 = m0[a];
        eo1 = m1[a];
      end
      if (wr) begin
        m0[a] = d;
        m1[a] = d;
      end
    end
    @(negedge clock);
    compare_all();
  endtask

  // Asynchronous reset pulse placed mid-cycle, just after a rising edge.
  task automatic do_reset(input string tag);
    @(posedge clock);
    #2 reset = 1'b0;
    #1 check_zero(tag);
    model_reset();
    rd_en = 1'b0; wr_en = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    rd_en = 1'b0; wr_en = 1'b0; addr = '0; din = '0;
    reset = 1'b1;
    #1 reset = 1'b0;
    #1 check_zero("por");
    model_reset();
    repeat (2) @(negedge clock);
    reset = 1'b1;

    // INIT with random requests that must be ignored; init_done after 32 edges
    for (int i = 0; i < 32; i++)
      step(1'($urandom), 1'($urandom), 5'($urandom), 16'($urandom));

    step(1, 0, 5'd0, 16'h0);
    step(1, 0, 5'd17, 16'h0);
    step(1, 0, 5'd31, 16'h0);
    step(1, 0, 5'd5, 16'h0);
    step(0, 0, 5'd0, 16'h0);

    step(0, 1, 5'd3, 16'hBEEF);
    step(1, 0, 5'd3, 16'h0);

    step(0, 1, 5'd9, 16'h1234);
    step(1, 1, 5'd9, 16'hAAAA);
    step(1, 0, 5'd9, 16'h0);

    step(1, 0, 5'd0, 16'h0);
    step(1, 0, 5'd1, 16'h0);
    step(1, 0, 5'd2, 16'h0);
    for (int i = 0; i < 3; i++) step(0, 0, 5'($urandom), 16'($urandom));

    step(0, 1, 5'd7, 16'h5555);
    for (int i = 0; i < 8; i++) step(0, 0, 5'd0, 16'h0);
    // a read is accepted on the edge right before reset hits
    rd_en = 1'b1; addr = 5'd7;
    do_reset("mid_serve");
    for (int i = 0; i < 32; i++) step(0, 0, 5'd0, 16'h0);
    step(1, 0, 5'd7, 16'h0);

    // reset mid-INIT, then randomized traffic from the first INIT cycle
    for (int i = 0; i < 10; i++) step(0, 0, 5'd0, 16'h0);
    do_reset("mid_init");
    begin
      logic [4:0] last_a;
      last_a = 5'd0;
      for (int i = 0; i < 400; i++) begin
        logic [4:0] a;
        a = ($urandom_range(0, 3) == 0) ? last_a : 5'($urandom_range(0, 31));
        last_a = a;
        step(1'($urandom), 1'($urandom), a, 16'($urandom));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
